// File: rtl/regfile_pkg.sv
// Shared defaults and the bypass priority helper for the multi-port register file.
// The read-data mux and the rd_busy logic both use the same priority helper.
package regfile_pkg;

    localparam int unsigned DATA_W_DEFAULT   = 32;
    localparam int unsigned ADDR_W_DEFAULT   = 5;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'hF000_0000;

    typedef enum logic [1:0] {
        SelStore,
        SelWa,
        SelWb
    } byp_sel_e;

    // Port B (memory return) outranks port A, which matches the write-collision winner.
    function automatic byp_sel_e byp_sel(input logic wb_hit, input logic wa_hit);
        if (wb_hit) begin
            return SelWb;
        end else if (wa_hit) begin
            return SelWa;
        end
        return SelStore;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register, set by load issue, cleared by memory return.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned NREGS  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    output logic [NREGS-1:0]  busy_o,
    output logic              busy_any_o
);

    logic [NREGS-1:0] busy_d, busy_q;

    // Set is applied last so a new load issued behind a returning one stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, ALU (A) and memory (B) write ports,
// optional hardwired-zero R0 and a load scoreboard for decode stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
    parameter int unsigned NUM_RD      = 2,
    parameter int unsigned ZERO_R0     = 0,
    parameter int unsigned SP_INDEX    = 31,
    parameter logic [31:0] SP_RESET    = SP_RESET_DEFAULT,
    parameter int unsigned DEBUG_INDEX = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    output logic                     busy_any,
    output logic [7:0]               debug_data
);

    localparam int unsigned        NREGS      = 2 ** ADDR_W;
    localparam bit                 ZERO_MODE  = (ZERO_R0 != 0);
    localparam logic [DATA_W-1:0]  SP_RST_VAL = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy;
    logic              wa_ok, wb_ok, mark_ok;

    // Reset gates the bypass as well as the commit, so outputs show reset values at once.
    assign wa_ok   = wa_en   && !reset && !(ZERO_MODE && (wa_addr   == '0));
    assign wb_ok   = wb_en   && !reset && !(ZERO_MODE && (wb_addr   == '0));
    assign mark_ok = mark_en && !reset && !(ZERO_MODE && (mark_addr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wa_ok) begin
            regs_d[wa_addr] = wa_data;
        end
        if (wb_ok) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if ((i == SP_INDEX) && !(ZERO_MODE && (i == 0))) begin
                    regs_q[i] <= SP_RST_VAL;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (mark_ok),
        .set_addr_i (mark_addr),
        .clr_en_i   (wb_ok),
        .clr_addr_i (wb_addr),
        .busy_o     (busy),
        .busy_any_o (busy_any)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rdata;
        logic              rbusy;
        logic              mark_hit;
        byp_sel_e          sel;

        assign ra       = rd_addr[k*ADDR_W +: ADDR_W];
        assign sel      = byp_sel(wb_ok && (wb_addr == ra), wa_ok && (wa_addr == ra));
        assign mark_hit = mark_ok && (mark_addr == ra);

        always_comb begin
            rdata = regs_q[ra];
            rbusy = busy[ra];
            if (ZERO_MODE && (ra == '0)) begin
                rdata = '0;
                rbusy = 1'b0;
            end else begin
                case (sel)
                    SelWb: begin
                        rdata = wb_data;
                        rbusy = mark_hit;
                    end
                    SelWa:   rdata = wa_data;
                    default: rdata = regs_q[ra];
                endcase
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rdata;
        assign rd_busy[k]                  = rbusy;
    end

    assign debug_data = regs_q[DEBUG_INDEX][7:0];

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the CPU's 2R/1W register file.
- Sits between decode (read ports) and writeback.
- Has two write ports: port A for ALU writeback, port B for memory-return writeback.
- Adds write-to-read bypass, optional hardwired-zero R0, and a per-register busy scoreboard so decode can stall on outstanding loads.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; NREGS = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- ZERO_R0, 0, when 1, register 0 reads as zero and ignores writes and marks.
- SP_INDEX, 31, register given a non-zero reset value.
- SP_RESET, 32'hF000_0000, reset value of register SP_INDEX (truncated/zero-extended to DATA_W).
- DEBUG_INDEX, 3, register whose low 8 bits drive debug_data.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  scoreboard busy bit of each read address.
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B (memory return) enable.
- wb_addr  in  ADDR_W  write port B address.
- wb_data  in  DATA_W  write port B data.
- mark_en  in  1  set busy for mark_addr (load issued).
- mark_addr  in  ADDR_W  register to mark busy.
- busy_any  out  1  OR of all busy bits.
- debug_data  out  8  regs[DEBUG_INDEX][7:0].

Behaviour:
- Reset (async assert, takes effect immediately):
  - All registers 0, except regs[SP_INDEX] = SP_RESET.
  - All busy bits 0.
  - Outputs during reset therefore read rd_data = 0 (or SP_RESET at SP_INDEX), rd_busy = 0, busy_any = 0, debug_data = regs[DEBUG_INDEX][7:0] reset value (0 unless DEBUG_INDEX == SP_INDEX).
  - Writes and marks during reset are ignored.
- Reads are combinational, zero latency, with same-cycle bypass:
  - If wb_en and wb_addr == rd_addr[k], rd_data[k] = wb_data.
  - Else if wa_en and wa_addr == rd_addr[k], rd_data[k] = wa_data.
  - Else rd_data[k] = stored value.
- Write commit on posedge clk when not in reset:
  - wa_en: regs[wa_addr] <= wa_data.
  - wb_en: regs[wb_addr] <= wb_data.
  - wa_addr == wb_addr, both enabled: port B wins, matching the bypass priority.
- Scoreboard:
  - Per-register busy bit.
  - wb_en clears busy[wb_addr] on posedge clk.
  - mark_en sets busy[mark_addr] on posedge clk.
  - Same address set and clear in the same cycle: set wins (new load issued behind the returning one).
  - wa_en does not affect busy.
  - Marking an already-busy register keeps it busy; no count is kept.
- rd_busy[k] = busy[rd_addr[k]], with bypass: a same-cycle wb_en to that address reports 0 unless mark_en targets the same address (then 1).
- busy_any reflects registered busy state only (no bypass).
- ZERO_R0 = 1:
  - Writes, marks and bypass to/from address 0 are suppressed.
  - rd_data for address 0 = 0; rd_busy for address 0 = 0.
  - If SP_INDEX == 0 in this mode, the zero rule dominates.
- Addresses are fully decoded (NREGS = 2**ADDR_W); no out-of-range case exists.
- Reset asserted mid-operation (pending busy, same-cycle writes): state is forced to reset values immediately; the first edge after deassert behaves normally.

Decomposition:
- Shared package regfile_pkg holds:
  - The default DATA_W and ADDR_W.
  - SP_RESET_DEFAULT = 32'hF000_0000.
  - A function computing the bypass/priority select, reused by the read mux and rd_busy.
- One natural sub-module: regfile_scoreboard, containing the NREGS busy bits with set/clear priority and busy_any.
- Storage and read bypass stay in regfile_mp, with a generate loop over NUM_RD.

Test Plan:
- Reset release -> every address reads 0 except addr 31 = 32'hF000_0000; debug_data = 8'h00; busy_any = 0.
- wa_en=1, wa_addr=3, wa_data=32'h0000_00A5, rd_addr[0]=3 in the same cycle -> rd_data[0] = 32'h0000_00A5 before the edge; debug_data = 8'hA5 after the edge.
- Write collision: wa_en and wb_en both to addr 7, wa_data = 32'h1111_1111, wb_data = 32'h2222_2222 -> same-cycle read and subsequent read both return 32'h2222_2222.
- Scoreboard sequence:
  - mark_en addr 9 -> next cycle rd_busy = 1 and busy_any = 1.
  - wb_en addr 9 with mark_en addr 9 in the same cycle -> still busy.
  - wb_en alone -> busy clears, busy_any = 0, and the register holds the last wb_data.
- ZERO_R0 = 1: wa_en addr 0 data 32'hDEAD_BEEF, plus mark_en addr 0 -> rd_data for addr 0 = 0, rd_busy = 0, busy_any = 0.
- Async reset pulse between clock edges while busy[4] = 1 and regs[5] = 32'h55 -> immediately busy_any = 0 and reg 5 reads 0; write attempts during reset are not committed.
